// File: rtl/frag_sb_pkg.sv
// Shared types for the fragment-count scoreboard: FSM states, expected-count entries, results.
// Struct fields are sized for the widest supported tag/count; narrower instances zero-extend.
package frag_sb_pkg;

    parameter int unsigned SbTagW = 8;
    parameter int unsigned SbCntW = 16;

    typedef enum logic [1:0] {
        StAccum,
        StWaitExp,
        StStop
    } state_e;

    typedef struct packed {
        logic [SbTagW-1:0] tag;
        logic [SbCntW-1:0] cnt;
    } exp_entry_t;

    typedef struct packed {
        logic [SbTagW-1:0] tag;
        logic [SbCntW-1:0] cnt;
        logic              err;
    } chk_result_t;

endpackage

// File: rtl/frag_sb_fifo.sv
// Synchronous FIFO of expected-count entries; wrap-bit pointers give the full/empty flags.
// Pushes when full and pops when empty are ignored.
module frag_sb_fifo
    import frag_sb_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  exp_entry_t wdata_i,
    output exp_entry_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    exp_entry_t  mem_q [Depth];
    logic        do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/frag_cnt_sb.sv
// Multi-lane fragment-count scoreboard: counts hits per triangle and checks against a FIFO of
// expected counts. Define FRAG_SB_STOP_ON_ERR_EN to halt on the first mismatch until reset.
module frag_cnt_sb
    import frag_sb_pkg::*;
#(
    parameter int unsigned LANES     = 2,
    parameter int unsigned TAG_W     = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned EXP_DEPTH = 8,
    parameter int unsigned ERR_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exp_valid_i,
    output logic             exp_ready_o,
    input  logic [TAG_W-1:0] exp_tag_i,
    input  logic [CNT_W-1:0] exp_cnt_i,
    input  logic [LANES-1:0] hit_valid_i,
    input  logic [TAG_W-1:0] hit_tag_i,
    input  logic             tri_done_i,
    output logic             hit_ready_o,
    output logic             chk_valid_o,
    output logic [TAG_W-1:0] chk_tag_o,
    output logic [CNT_W-1:0] chk_cnt_o,
    output logic             chk_err_o,
    output logic [ERR_W-1:0] err_total_o,
    output logic             halted_o
);

    localparam int unsigned PcW  = 4;
    localparam int unsigned SumW = CNT_W + PcW;
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             sat_q, sat_d;
    chk_result_t      chk_q, chk_d;
    logic             chk_valid_q, chk_valid_d;
    logic [ERR_W-1:0] err_total_q, err_total_d;

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    exp_entry_t       fifo_wdata, fifo_head;

    logic [PcW-1:0]   pc;
    logic [SumW-1:0]  sum_wide;
    logic [CNT_W-1:0] sum;
    logic             sat_now;
    logic             cmp_fire, cmp_sat, cmp_err;
    logic [CNT_W-1:0] cmp_cnt;
    logic [TAG_W-1:0] cmp_tag;
    logic             unused_chk;

    always_comb begin
        pc = '0;
        for (int i = 0; i < LANES; i++) pc = pc + PcW'(hit_valid_i[i]);
        sum_wide = SumW'(cnt_q) + SumW'(pc);
        sat_now  = sat_q;
        sum      = sum_wide[CNT_W-1:0];
        if (sum_wide > SumW'(CntMax)) begin
            sum     = CntMax;
            sat_now = 1'b1;
        end
    end

    assign fifo_push  = exp_valid_i & exp_ready_o;
    assign fifo_wdata = '{tag: SbTagW'(exp_tag_i), cnt: SbCntW'(exp_cnt_i)};

    frag_sb_fifo #(
        .Depth(EXP_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= StAccum;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StAccum:   if (tri_done_i && fifo_empty) state_d = StWaitExp;
            StWaitExp: if (!fifo_empty) state_d = StAccum;
            default:   state_d = state_q;
        endcase
`ifdef FRAG_SB_STOP_ON_ERR_EN
        if (cmp_fire && cmp_err) state_d = StStop;
`endif
    end

    always_comb begin
        hit_ready_o = 1'b0;
        exp_ready_o = ~fifo_full;
        halted_o    = 1'b0;
        case (state_q)
            StAccum: hit_ready_o = 1'b1;
            StStop: begin
                exp_ready_o = 1'b0;
`ifdef FRAG_SB_STOP_ON_ERR_EN
                halted_o = 1'b1;
`endif
            end
            default: hit_ready_o = 1'b0;
        endcase
    end

    // WAIT_EXP compares the triangle latched into cnt_q/tag_q/sat_q when the FIFO was empty.
    always_comb begin
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        sat_d    = sat_q;
        cmp_fire = 1'b0;
        fifo_pop = 1'b0;
        cmp_cnt  = sum;
        cmp_tag  = hit_tag_i;
        cmp_sat  = sat_now;
        case (state_q)
            StAccum: begin
                cnt_d = sum;
                sat_d = sat_now;
                if (tri_done_i) begin
                    if (!fifo_empty) begin
                        cmp_fire = 1'b1;
                        fifo_pop = 1'b1;
                        cnt_d    = '0;
                        sat_d    = 1'b0;
                    end else begin
                        tag_d = hit_tag_i;
                    end
                end
            end
            StWaitExp: begin
                cmp_cnt = cnt_q;
                cmp_tag = tag_q;
                cmp_sat = sat_q;
                if (!fifo_empty) begin
                    cmp_fire = 1'b1;
                    fifo_pop = 1'b1;
                    cnt_d    = '0;
                    sat_d    = 1'b0;
                end
            end
            default: ;
        endcase
        cmp_err = (fifo_head.cnt != SbCntW'(cmp_cnt)) | (fifo_head.tag != SbTagW'(cmp_tag)) |
                  cmp_sat;
    end

    always_comb begin
        chk_valid_d = cmp_fire;
        chk_d       = chk_q;
        err_total_d = err_total_q;
        if (cmp_fire) chk_d = '{tag: SbTagW'(cmp_tag), cnt: SbCntW'(cmp_cnt), err: cmp_err};
        if (cmp_fire && cmp_err && !(&err_total_q)) err_total_d = err_total_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            tag_q       <= '0;
            sat_q       <= 1'b0;
            chk_q       <= '0;
            chk_valid_q <= 1'b0;
            err_total_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            sat_q       <= sat_d;
            chk_q       <= chk_d;
            chk_valid_q <= chk_valid_d;
            err_total_q <= err_total_d;
        end
    end

    assign chk_valid_o = chk_valid_q;
    assign chk_tag_o   = chk_q.tag[TAG_W-1:0];
    assign chk_cnt_o   = chk_q.cnt[CNT_W-1:0];
    assign chk_err_o   = chk_q.err;
    assign err_total_o = err_total_q;
    // Upper struct bits stay zero when TAG_W/CNT_W are narrower than the package widths.
    assign unused_chk  = ^{chk_q.tag, chk_q.cnt};

endmodule

// File: tb/tb_frag_cnt_sb.sv
// Scoreboard bench for frag_cnt_sb: directed triangles, expected results queued at stimulus time
// and popped by per-instance monitors on each chk_valid strobe.
module tb_frag_cnt_sb;

    typedef struct {
        int tag;
        int cnt;
        int err;
        int et;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int a_err_model = 0;
    int b_err_model = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    // Instance A: default widths
    logic        a_exp_valid = 0, a_exp_ready, a_tri_done = 0, a_hit_ready;
    logic [7:0]  a_exp_tag = 0, a_hit_tag = 0, a_chk_tag;
    logic [15:0] a_exp_cnt = 0, a_chk_cnt, a_err_total;
    logic [1:0]  a_hit_valid = 0;
    logic        a_chk_valid, a_chk_err, a_halted;

    // Instance B: 4-bit counter for saturation
    logic        b_exp_valid = 0, b_exp_ready, b_tri_done = 0, b_hit_ready;
    logic [7:0]  b_exp_tag = 0, b_hit_tag = 0, b_chk_tag;
    logic [3:0]  b_exp_cnt = 0, b_chk_cnt;
    logic [15:0] b_err_total;
    logic [1:0]  b_hit_valid = 0;
    logic        b_chk_valid, b_chk_err, b_halted;

    frag_cnt_sb #(.LANES(2), .TAG_W(8), .CNT_W(16), .EXP_DEPTH(8), .ERR_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .exp_valid_i(a_exp_valid), .exp_ready_o(a_exp_ready),
        .exp_tag_i(a_exp_tag), .exp_cnt_i(a_exp_cnt),
        .hit_valid_i(a_hit_valid), .hit_tag_i(a_hit_tag), .tri_done_i(a_tri_done),
        .hit_ready_o(a_hit_ready), .chk_valid_o(a_chk_valid), .chk_tag_o(a_chk_tag),
        .chk_cnt_o(a_chk_cnt), .chk_err_o(a_chk_err), .err_total_o(a_err_total),
        .halted_o(a_halted)
    );

    frag_cnt_sb #(.LANES(2), .TAG_W(8), .CNT_W(4), .EXP_DEPTH(8), .ERR_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .exp_valid_i(b_exp_valid), .exp_ready_o(b_exp_ready),
        .exp_tag_i(b_exp_tag), .exp_cnt_i(b_exp_cnt),
        .hit_valid_i(b_hit_valid), .hit_tag_i(b_hit_tag), .tri_done_i(b_tri_done),
        .hit_ready_o(b_hit_ready), .chk_valid_o(b_chk_valid), .chk_tag_o(b_chk_tag),
        .chk_cnt_o(b_chk_cnt), .chk_err_o(b_chk_err), .err_total_o(b_err_total),
        .halted_o(b_halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input int tag, input int cnt, input int err);
        if (err != 0) a_err_model++;
        q_a.push_back('{tag, cnt, err, a_err_model});
    endtask

    task automatic a_push(input int tag, input int cnt);
        a_exp_valid = 1'b1;
        a_exp_tag   = 8'(tag);
        a_exp_cnt   = 16'(cnt);
        tick();
        a_exp_valid = 1'b0;
    endtask

    task automatic a_hits(input logic [1:0] v, input int tag, input bit done);
        int n = 0;
        a_hit_valid = v;
        a_hit_tag   = 8'(tag);
        a_tri_done  = done;
        while (a_hit_ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        if (a_hit_ready !== 1'b1) chk("a_hit_ready_timeout", a_hit_ready, 1);
        tick();
        a_hit_valid = '0;
        a_tri_done  = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_chk_valid"}, a_chk_valid, 0);
        chk({tag, "_chk_tag"}, a_chk_tag, 0);
        chk({tag, "_chk_cnt"}, a_chk_cnt, 0);
        chk({tag, "_chk_err"}, a_chk_err, 0);
        chk({tag, "_err_total"}, a_err_total, 0);
        chk({tag, "_hit_ready"}, a_hit_ready, 1);
        chk({tag, "_exp_ready"}, a_exp_ready, 1);
        chk({tag, "_halted"}, a_halted, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        if (q_a.size() != 0) chk("a_pending_results", q_a.size(), 0);
        if (q_b.size() != 0) chk("b_pending_results", q_b.size(), 0);
    endtask

    always @(negedge clk) begin
        if (a_chk_valid === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_strobe: got tag %0d, required no strobe", a_chk_tag);
            end else begin
                ea = q_a.pop_front();
                chk("a_chk_tag", a_chk_tag, ea.tag);
                chk("a_chk_cnt", a_chk_cnt, ea.cnt);
                chk("a_chk_err", a_chk_err, ea.err);
                chk("a_err_total", a_err_total, ea.et);
            end
        end
        if (b_chk_valid === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_strobe: got tag %0d, required no strobe", b_chk_tag);
            end else begin
                eb = q_b.pop_front();
                chk("b_chk_tag", b_chk_tag, eb.tag);
                chk("b_chk_cnt", b_chk_cnt, eb.cnt);
                chk("b_chk_err", b_chk_err, eb.err);
                chk("b_err_total", b_err_total, eb.et);
            end
        end
    end

    initial begin
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        check_reset_a("rst");

        // Hits 2,2,1 on tag 3
        expect_a(3, 5, 0);
        a_push(3, 5);
        a_hits(2'b11, 3, 0);
        a_hits(2'b11, 3, 0);
        a_hits(2'b01, 3, 1);

        // Saturation on the 4-bit instance: 20 hits, expected 15
        b_err_model++;
        q_b.push_back('{40, 15, 1, b_err_model});
        b_exp_valid = 1'b1; b_exp_tag = 8'd40; b_exp_cnt = 4'd15;
        tick();
        b_exp_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            b_hit_valid = 2'b11; b_hit_tag = 8'd40; b_tri_done = (i == 9);
            tick();
        end
        b_hit_valid = '0; b_tri_done = 1'b0;
        // Sticky sat must clear for the next triangle
        q_b.push_back('{41, 2, 0, b_err_model});
        b_exp_valid = 1'b1; b_exp_tag = 8'd41; b_exp_cnt = 4'd2;
        tick();
        b_exp_valid = 1'b0;
        b_hit_valid = 2'b11; b_hit_tag = 8'd41; b_tri_done = 1'b1;
        tick();
        b_hit_valid = '0; b_tri_done = 1'b0;
        drain();

`ifdef FRAG_SB_STOP_ON_ERR_EN
        expect_a(4, 7, 1);
        a_push(4, 6);
        a_hits(2'b11, 4, 0);
        a_hits(2'b11, 4, 0);
        a_hits(2'b11, 4, 0);
        a_hits(2'b01, 4, 1);
        chk("stop_halted", a_halted, 1);
        chk("stop_hit_ready", a_hit_ready, 0);
        chk("stop_exp_ready", a_exp_ready, 0);
        drain();
        tick();
        chk("stop_still_halted", a_halted, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        a_err_model = 0;
        check_reset_a("stop_rst");
        a_hits(2'b01, 60, 1);
        chk("stop_rst_fifo_empty", a_hit_ready, 0);
        expect_a(60, 1, 0);
        a_push(60, 1);
        tick();
        drain();
`else
        // Count mismatch (7 hits vs 6), then a clean triangle
        expect_a(4, 7, 1);
        a_push(4, 6);
        a_hits(2'b11, 4, 0);
        a_hits(2'b11, 4, 0);
        a_hits(2'b11, 4, 0);
        a_hits(2'b01, 4, 1);
        expect_a(5, 2, 0);
        a_push(5, 2);
        a_hits(2'b11, 5, 1);
        chk("no_stop_halted", a_halted, 0);

        // Tag mismatch, zero-hit triangle, tag change without tri_done
        expect_a(10, 3, 1);
        a_push(9, 3);
        a_hits(2'b11, 10, 0);
        a_hits(2'b01, 10, 1);
        expect_a(11, 0, 0);
        a_push(11, 0);
        a_hits(2'b00, 11, 1);
        expect_a(12, 3, 0);
        a_push(12, 3);
        a_hits(2'b01, 13, 0);
        a_hits(2'b11, 12, 1);
        drain();

        // tri_done with FIFO empty waits for the expected entry
        a_hits(2'b11, 7, 0);
        a_hits(2'b11, 7, 1);
        for (int i = 0; i < 3; i++) begin
            chk("wait_hit_ready", a_hit_ready, 0);
            tick();
        end
        expect_a(7, 4, 0);
        a_push(7, 4);
        chk("wait_push_hit_ready", a_hit_ready, 0);
        chk("wait_push_chk_valid", a_chk_valid, 0);
        tick();
        chk("wait_done_chk_valid", a_chk_valid, 1);
        chk("wait_done_hit_ready", a_hit_ready, 1);
        drain();

        // Fill FIFO; ninth push dropped
        for (int i = 0; i < 8; i++) a_push(20 + i, 1);
        chk("full_exp_ready", a_exp_ready, 0);
        a_exp_valid = 1'b1; a_exp_tag = 8'd99; a_exp_cnt = 16'd9;
        tick();
        a_exp_valid = 1'b0;
        chk("full_exp_ready_held", a_exp_ready, 0);
        for (int i = 0; i < 8; i++) begin
            expect_a(20 + i, 1, 0);
            a_hits(2'b01, 20 + i, 1);
        end
        chk("drained_exp_ready", a_exp_ready, 1);
        a_hits(2'b01, 30, 1);
        chk("drained_fifo_empty", a_hit_ready, 0);
        expect_a(30, 1, 0);
        a_push(30, 1);
        tick();
        drain();

        // Mid-operation reset discards partial count and FIFO contents
        a_push(50, 1);
        a_hits(2'b01, 50, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        a_err_model = 0;
        b_err_model = 0;
        check_reset_a("mid_rst");
        chk("mid_rst_b_err_total", b_err_total, 0);
        a_hits(2'b01, 51, 1);
        chk("mid_rst_fifo_empty", a_hit_ready, 0);
        expect_a(51, 1, 0);
        a_push(51, 1);
        tick();
        drain();
`endif
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
